temp_sense_ctrl: RTL and testbench

TEMP_SENSE_CTRL -- requirements
Module: temp_sense_ctrl

---
 rtl/temp_sense_ctrl_if.sv | 22 ++
 rtl/temp_sense_ctrl.sv | 159 +++++++++++++++
 tb/tb_temp_sense_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_sense_ctrl_if.sv
// Handshake between the temperature-sense controller and the ring-oscillator
// measurement block. The controller is the master: it issues a start pulse
// and receives done plus the measured cycle count.
interface temp_sense_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             meas_start;
  logic             meas_done;
  logic [WIDTH-1:0] meas_cycles;

  modport master (
    output meas_start,
    input  meas_done,
    input  meas_cycles
  );

  modport slave (
    input  meas_start,
    output meas_done,
    output meas_cycles
  );
endinterface

// File: rtl/temp_sense_ctrl.sv
// Temperature-sense sequencer: periodically triggers the measurement block,
// averages 2^AVG_LOG2 results, raises a hysteretic over-temperature alarm and
// flags handshake timeouts. Everything runs on the 32.768 kHz lf_clk.
module temp_sense_ctrl #(
  parameter int WIDTH    = 10,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD_W = 16
)(
  input  logic                lf_clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WIDTH-1:0]    thr_hi,
  input  logic [WIDTH-1:0]    thr_lo,
  temp_sense_ctrl_if.master   meas,
  output logic [WIDTH-1:0]    avg,
  output logic                avg_valid,
  output logic                alarm,
  output logic                busy,
  output logic                err
);

  localparam int ACC_W  = WIDTH + AVG_LOG2;
  // Keep the sample counter at least one bit wide so AVG_LOG2=0 still elaborates.
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);
  // Last in-state cycle index before the handshake is declared dead.
  localparam logic [2:0] TMO_LOW  = 3'd3;
  localparam logic [2:0] TMO_HIGH = 3'd7;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_LOW    = 3'd2,
    WAIT_HIGH   = 3'd3,
    WAIT_PERIOD = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [2:0]          tcnt;
  logic [PERIOD_W-1:0] pcnt;
  logic [ACC_W-1:0]    acc;
  logic [SCNT_W-1:0]   scnt;

  logic                cap, tmo, last;
  logic [ACC_W-1:0]    acc_sum;
  logic [WIDTH-1:0]    avg_new;

  logic                start_nx, busy_nx, vld_nx, alarm_nx, err_nx;
  logic [WIDTH-1:0]    avg_nx;

  assign cap     = (state == WAIT_HIGH) && meas.meas_done;
  assign tmo     = ((state == WAIT_LOW)  &&  meas.meas_done && (tcnt == TMO_LOW)) ||
                   ((state == WAIT_HIGH) && !meas.meas_done && (tcnt == TMO_HIGH));
  assign last    = (scnt == SCNT_LAST);
  assign acc_sum = acc + ACC_W'(meas.meas_cycles);
  assign avg_new = WIDTH'(acc_sum >> AVG_LOG2);

  // State register.
  always_ff @(posedge lf_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode. Done is tested before the timeout count so a late but
  // valid handshake edge on the final allowed cycle is still accepted.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (en) state_nx = START;
      START:       state_nx = WAIT_LOW;
      WAIT_LOW:    if (!meas.meas_done)      state_nx = WAIT_HIGH;
                   else if (tcnt == TMO_LOW) state_nx = IDLE;
      WAIT_HIGH:   if (meas.meas_done)        state_nx = WAIT_PERIOD;
                   else if (tcnt == TMO_HIGH) state_nx = IDLE;
      WAIT_PERIOD: if (!en)              state_nx = IDLE;
                   else if (pcnt == '0)  state_nx = START;
      default:     state_nx = IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    start_nx = (state_nx == START);
    busy_nx  = (state_nx != IDLE);
    vld_nx   = cap && last;
    avg_nx   = avg;
    alarm_nx = alarm;
    err_nx   = err;
    if (cap && last) begin
      avg_nx = avg_new;
      // Set is checked first so it wins when thr_lo > thr_hi.
      if (avg_new > thr_hi)      alarm_nx = 1'b1;
      else if (avg_new < thr_lo) alarm_nx = 1'b0;
    end
    if (tmo)                        err_nx = 1'b1;
    else if (state == IDLE && !en)  err_nx = 1'b0;
  end

  // Output registers.
  always_ff @(posedge lf_clk or posedge reset) begin
    if (reset) begin
      meas.meas_start <= 1'b0;
      busy            <= 1'b0;
      avg_valid       <= 1'b0;
      avg             <= '0;
      alarm           <= 1'b0;
      err             <= 1'b0;
    end else begin
      meas.meas_start <= start_nx;
      busy            <= busy_nx;
      avg_valid       <= vld_nx;
      avg             <= avg_nx;
      alarm           <= alarm_nx;
      err             <= err_nx;
    end
  end

  // Handshake timeout counter: cycles spent in the current wait state.
  always_ff @(posedge lf_clk or posedge reset) begin
    if (reset)
      tcnt <= '0;
    else if ((state == WAIT_LOW || state == WAIT_HIGH) && state_nx == state)
      tcnt <= tcnt + 3'd1;
    else
      tcnt <= '0;
  end

  // Inter-sample idle counter, loaded with period as WAIT_PERIOD is entered.
  always_ff @(posedge lf_clk or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (cap)
      pcnt <= period;
    else if (state == WAIT_PERIOD && pcnt != '0)
      pcnt <= pcnt - PERIOD_W'(1);
  end

  // Accumulator and sample count. A partial sum survives en=0 in WAIT_PERIOD
  // but is dropped on a timeout since the group's timing is no longer uniform.
  always_ff @(posedge lf_clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      scnt <= '0;
    end else if (tmo) begin
      acc  <= '0;
      scnt <= '0;
    end else if (cap) begin
      if (last) begin
        acc  <= '0;
        scnt <= '0;
      end else begin
        acc  <= acc_sum;
        scnt <= scnt + SCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_temp_sense_ctrl.sv
// Bench for temp_sense_ctrl: drives the measurement handshake with random
// response delays and predicts averages/alarm from the sample list.
module tb_temp_sense_ctrl;

  logic       lf_clk = 1'b0;
  logic       reset;
  logic       en;
  logic [15:0] period;
  logic [9:0] thr_hi, thr_lo;
  logic [9:0] avg;
  logic       avg_valid, alarm, busy, err;
  logic       meas_start;

  temp_sense_ctrl_if #(.WIDTH(10)) mif();

  temp_sense_ctrl #(.WIDTH(10), .AVG_LOG2(2), .PERIOD_W(16)) dut (
    .lf_clk(lf_clk), .reset(reset), .en(en), .period(period),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .meas(mif),
    .avg(avg), .avg_valid(avg_valid), .alarm(alarm), .busy(busy), .err(err)
  );

  assign meas_start = mif.meas_start;

  always #5 lf_clk = ~lf_clk;

  int cyc = 0;
  always @(posedge lf_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int q[$];
  int m_avg = 0, m_alarm = 0;
  int t_last = 0, g = 0;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge lf_clk); #1;
  endtask

  // Reference: collect samples; every fourth closes a group whose mean
  // (truncated) becomes avg, then the alarm follows the hysteresis rule.
  task automatic m_cap(input int c, output bit v);
    int s;
    q.push_back(c);
    v = 0;
    if (q.size() == 4) begin
      s = 0;
      foreach (q[i]) s += q[i];
      m_avg = s / 4;
      if (m_avg > int'(thr_hi))      m_alarm = 1;
      else if (m_avg < int'(thr_lo)) m_alarm = 0;
      v = 1;
      q.delete();
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 0;
    for (int w = 0; w < 100; w++) begin
      if (meas_start === 1'b1) begin seen = 1; break; end
      step();
    end
    chk("start_seen", {31'd0, seen}, 1);
  endtask

  // One conversion: done stays high for ld more WAIT_LOW cycles, then low for
  // hd+1 WAIT_HIGH cycles before returning with count c.
  task automatic do_conv(input int ld, input int hd, input int c,
                         input bit drop_en, input int exp_gap);
    bit seen, v;
    wait_start(seen);
    if (!seen) return;
    if (exp_gap > 0) chk("start_gap", cyc - t_last, exp_gap);
    t_last = cyc;
    if (drop_en) en = 0;
    step();
    chk("start_width", {31'd0, meas_start}, 0);
    repeat (ld) step();
    mif.meas_done = 0;
    repeat (hd + 1) step();
    chk("busy_conv", {31'd0, busy}, 1);
    mif.meas_done = 1;
    mif.meas_cycles = 10'(c);
    step();
    m_cap(c, v);
    chk("avg_valid", {31'd0, avg_valid}, {31'd0, v});
    if (v) begin
      chk("avg", {22'd0, avg}, m_avg);
      chk("alarm", {31'd0, alarm}, m_alarm);
    end
    step();
    chk("avg_valid_width", {31'd0, avg_valid}, 0);
  endtask

  task automatic conv_r(input int c, input bit use_gap);
    int ld, hd;
    ld = $urandom_range(3, 0);
    hd = $urandom_range(7, 0);
    do_conv(ld, hd, c, 0, use_gap ? g : 0);
    g = ld + hd + 4 + int'(period);
  endtask

  task automatic do_tmo_low(input bit drop_en);
    bit seen;
    wait_start(seen);
    if (!seen) return;
    if (drop_en) en = 0;
    repeat (4) step();
    chk("tmo_low_busy", {31'd0, busy}, 1);
    step();
    chk("tmo_low_err", {31'd0, err}, 1);
    chk("tmo_low_idle", {31'd0, busy}, 0);
    chk("tmo_low_avg", {22'd0, avg}, m_avg);
    chk("tmo_low_alarm", {31'd0, alarm}, m_alarm);
    q.delete();
    step();
    chk("tmo_low_err_after", {31'd0, err}, drop_en ? 0 : 1);
  endtask

  task automatic do_tmo_high();
    bit seen;
    wait_start(seen);
    if (!seen) return;
    mif.meas_done = 0;
    repeat (9) step();
    chk("tmo_high_busy", {31'd0, busy}, 1);
    step();
    chk("tmo_high_err", {31'd0, err}, 1);
    chk("tmo_high_idle", {31'd0, busy}, 0);
    chk("tmo_high_avg", {22'd0, avg}, m_avg);
    mif.meas_done = 1;
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg"}, {22'd0, avg}, 0);
    chk({tag, "_avg_valid"}, {31'd0, avg_valid}, 0);
    chk({tag, "_alarm"}, {31'd0, alarm}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_start"}, {31'd0, meas_start}, 0);
  endtask

  initial begin
    bit seen;
    int hi, lo;
    reset = 1; en = 0; period = 0; thr_hi = 10'd1023; thr_lo = 10'd0;
    mif.meas_done = 1; mif.meas_cycles = 0;
    repeat (3) step();
    chk_zero("reset");
    reset = 0;
    step();
    chk("idle_busy", {31'd0, busy}, 0);

    // basic averaging
    period = 3; en = 1;
    conv_r(100, 0); conv_r(102, 1); conv_r(104, 1); conv_r(106, 1);
    chk("basic_avg", {22'd0, avg}, 103);
    chk("basic_alarm", {31'd0, alarm}, 0);

    // start spacing with period 5
    period = 5;
    repeat (4) conv_r($urandom_range(1023, 0), 1);

    // hysteresis
    thr_hi = 10'd500; thr_lo = 10'd400;
    repeat (4) conv_r(510, 1);
    chk("hyst_510", {31'd0, alarm}, 1);
    repeat (4) conv_r(450, 1);
    chk("hyst_450", {31'd0, alarm}, 1);
    repeat (4) conv_r(390, 1);
    chk("hyst_390", {31'd0, alarm}, 0);

    // extremes and truncation
    thr_hi = 10'd1023; thr_lo = 10'd0;
    repeat (4) conv_r(1023, 1);
    chk("max_avg", {22'd0, avg}, 1023);
    conv_r(1, 1); conv_r(1, 1); conv_r(1, 1); conv_r(2, 1);
    chk("trunc_avg", {22'd0, avg}, 1);

    // random thresholds (including inverted ones), periods and samples
    for (int k = 0; k < 12; k++) begin
      hi = $urandom_range(1023, 0);
      lo = $urandom_range(1023, 0);
      thr_hi = 10'(hi); thr_lo = 10'(lo);
      period = 16'($urandom_range(4, 0));
      conv_r($urandom_range(1023, 0), 1);
    end

    // en dropped in WAIT_PERIOD keeps the partial sum
    thr_hi = 10'd1023; thr_lo = 10'd0;
    period = 6;
    while (q.size() != 0) conv_r(50, 1);
    conv_r(300, 1); conv_r(310, 1);
    en = 0;
    step();
    chk("wp_drop_busy", {31'd0, busy}, 0);
    repeat (3) step();
    chk("wp_drop_busy_hold", {31'd0, busy}, 0);
    chk("wp_drop_start", {31'd0, meas_start}, 0);
    en = 1;
    conv_r(320, 0); conv_r(330, 0);
    chk("resume_avg", {22'd0, avg}, 315);

    // en dropped mid-conversion lets it finish
    do_conv(2, 3, 700, 1, 0);
    chk("conv_drop_busy", {31'd0, busy}, 0);
    en = 1;

    // WAIT_LOW timeout cleared by en=0, partial sample discarded
    conv_r(900, 0);
    do_tmo_low(1);
    en = 1;
    // sticky error while en stays high
    do_tmo_low(0);
    conv_r(40, 0);
    chk("err_sticky", {31'd0, err}, 1);
    en = 0;
    repeat (4) step();
    chk("err_clear", {31'd0, err}, 0);
    en = 1;
    // WAIT_HIGH timeout
    conv_r(800, 0);
    do_tmo_high();
    en = 0;
    repeat (2) step();
    chk("err_clear_hi", {31'd0, err}, 0);
    en = 1;
    repeat (4) conv_r(60, 0);
    chk("post_tmo_avg", {22'd0, avg}, 60);

    // reset in WAIT_HIGH after two captured samples
    conv_r(150, 0); conv_r(250, 0);
    wait_start(seen);
    mif.meas_done = 0;
    repeat (3) step();
    #2 reset = 1;
    #1 chk_zero("mid_reset");
    step();
    reset = 0;
    mif.meas_done = 1;
    q.delete(); m_avg = 0; m_alarm = 0;
    chk("post_reset_valid", {31'd0, avg_valid}, 0);
    repeat (4) conv_r(200, 0);
    chk("post_reset_avg", {22'd0, avg}, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
